// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: two-flop synchronizer, counter debounce,
// one-cycle press/release pulses and an optional long-press auto-repeat train.
module btn_conditioner #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned STABLE_CNT = 16,
  parameter int unsigned HOLD_CNT   = 50000000,
  parameter int unsigned REPEAT_CNT = 12500000,
  parameter int unsigned REPEAT_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_rpt
);

  localparam int unsigned SW      = $clog2(STABLE_CNT + 1);
  localparam int unsigned MAX_CNT = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int unsigned HW      = $clog2(MAX_CNT + 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } hold_state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic [SW-1:0] stab_q;
    logic          flip_c;

    // Level flips once the synchronized input has disagreed for STABLE_CNT edges.
    assign flip_c = (sync_q2 != level_q) && (stab_q == SW'(STABLE_CNT - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q1   <= 1'b0;
        sync_q2   <= 1'b0;
        stab_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q1 <= btn_in[i];
        sync_q2 <= sync_q1;
        if ((sync_q2 == level_q) || flip_c) begin
          stab_q <= '0;
        end else begin
          stab_q <= stab_q + SW'(1);
        end
        if (flip_c) begin
          level_q <= sync_q2;
        end
        press_q   <= flip_c & sync_q2;
        release_q <= flip_c & ~sync_q2;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    if (REPEAT_EN != 0) begin : g_rpt
      hold_state_e   state_q;
      logic [HW-1:0] hold_q;
      logic          first_q;
      logic          rpt_q;

      // The first interval after a press uses HOLD_CNT, later ones REPEAT_CNT.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
          first_q <= 1'b0;
          rpt_q   <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (flip_c && sync_q2) begin
            state_q <= ST_HOLD;
            hold_q  <= HW'(1);
            first_q <= 1'b1;
          end else if (flip_c) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            first_q <= 1'b0;
          end else if (state_q == ST_HOLD) begin
            if (hold_q == (first_q ? HW'(HOLD_CNT) : HW'(REPEAT_CNT))) begin
              rpt_q   <= 1'b1;
              hold_q  <= HW'(1);
              first_q <= 1'b0;
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
      end

      assign btn_rpt[i] = rpt_q;
    end else begin : g_no_rpt
      assign btn_rpt[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: hand-derived vector table, test-plan sequences and
// randomized traffic checked against a sample-history reference model.
module tb_btn_conditioner;

  localparam int N_CH   = 4;
  localparam int STABLE = 4;
  localparam int HOLD   = 20;
  localparam int REPEAT = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn_in = '0;

  logic [N_CH-1:0] a_level, a_press, a_release, a_rpt;
  logic [N_CH-1:0] b_level, b_press, b_release, b_rpt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_CH(N_CH), .STABLE_CNT(STABLE), .HOLD_CNT(HOLD), .REPEAT_CNT(REPEAT), .REPEAT_EN(1)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(a_level), .btn_press(a_press), .btn_release(a_release), .btn_rpt(a_rpt)
  );

  btn_conditioner #(
    .N_CH(N_CH), .STABLE_CNT(STABLE), .HOLD_CNT(HOLD), .REPEAT_CNT(REPEAT), .REPEAT_EN(0)
  ) u_dut_norpt (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(b_level), .btn_press(b_press), .btn_release(b_release), .btn_rpt(b_rpt)
  );

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips when the last STABLE synchronized samples
  // (input delayed by two edges) all disagree with it; repeat timing is plain
  // arithmetic on the number of edges since the press.
  logic [N_CH-1:0] samp[$];
  logic [N_CH-1:0] m_level, m_press, m_release, m_rpt;
  logic [N_CH-1:0] m_flip, m_next, m_s;
  int              press_edge[N_CH];
  int              edge_n;
  int              m_idx;
  int              m_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp.delete();
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_rpt     = '0;
      edge_n    = 0;
      for (int i = 0; i < N_CH; i++) press_edge[i] = 0;
    end else begin
      edge_n++;
      samp.push_back(btn_in);
      if (samp.size() > STABLE + 4) void'(samp.pop_front());
      m_flip = '1;
      for (int j = 0; j < STABLE; j++) begin
        m_idx = samp.size() - 3 - j;
        m_s   = (m_idx >= 0) ? samp[m_idx] : '0;
        for (int i = 0; i < N_CH; i++) begin
          if (m_s[i] == m_level[i]) m_flip[i] = 1'b0;
        end
      end
      m_next    = m_level ^ m_flip;
      m_press   = m_flip & m_next;
      m_release = m_flip & ~m_next;
      for (int i = 0; i < N_CH; i++) begin
        if (m_press[i]) press_edge[i] = edge_n;
        m_d = edge_n - press_edge[i];
        m_rpt[i] = m_level[i] && m_next[i] && (m_d >= HOLD) && (((m_d - HOLD) % REPEAT) == 0);
      end
      m_level = m_next;
    end
  end

  // Every cycle both builds are compared against the model.
  always @(negedge clk) begin
    check("model_a_level", a_level, m_level);
    check("model_a_press", a_press, m_press);
    check("model_a_release", a_release, m_release);
    check("model_a_rpt", a_rpt, m_rpt);
    check("model_b_level", b_level, m_level);
    check("model_b_press", b_press, m_press);
    check("model_b_release", b_release, m_release);
    check("model_b_rpt", b_rpt, 4'b0000);
  end

  typedef struct {
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] prs;
    logic [N_CH-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [N_CH-1:0] btn, input logic [N_CH-1:0] lvl,
                     input logic [N_CH-1:0] prs, input logic [N_CH-1:0] rel, input int n);
    vec_t v;
    v.btn = btn; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, a_level, 4'b0000);
    check({tag, "_press"}, a_press, 4'b0000);
    check({tag, "_release"}, a_release, 4'b0000);
    check({tag, "_rpt"}, a_rpt, 4'b0000);
    check({tag, "_b_level"}, b_level, 4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst    = 1'b1;
    btn_in = 4'b1111;
    idle(3);
    check_all_zero("reset");
    btn_in = '0;
    idle(1);
    rst = 1'b0;

    // Clean press/release on ch0, then the bounce pattern on ch1
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1);
    add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);

    foreach (vecs[j]) begin
      btn_in = vecs[j].btn;
      @(negedge clk);
      check($sformatf("tbl%0d_level", j), a_level, vecs[j].lvl);
      check($sformatf("tbl%0d_press", j), a_press, vecs[j].prs);
      check($sformatf("tbl%0d_release", j), a_release, vecs[j].rel);
      check($sformatf("tbl%0d_rpt", j), a_rpt, 4'b0000);
    end
    idle(5);

    // Long hold on ch2: repeat train, then release
    btn_in = 4'b0100;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("hold_press", a_press, (n == 6) ? 4'b0100 : 4'b0000);
    end
    for (int off = 1; off <= 75; off++) begin
      @(negedge clk);
      check($sformatf("hold_rpt_%0d", off), a_rpt,
            (off inside {20, 28, 36, 44, 52, 60}) ? 4'b0100 : 4'b0000);
      check($sformatf("hold_norpt_%0d", off), b_rpt, 4'b0000);
      if (off > 60) begin
        check($sformatf("hold_release_%0d", off), a_release, (off == 66) ? 4'b0100 : 4'b0000);
        check($sformatf("hold_b_release_%0d", off), b_release, (off == 66) ? 4'b0100 : 4'b0000);
        check($sformatf("hold_level_%0d", off), a_level, (off < 66) ? 4'b0100 : 4'b0000);
      end
      if (off == 60) btn_in = 4'b0000;
    end
    idle(3);

    // Simultaneous press on ch0 and ch3, release ch3 only
    btn_in = 4'b1001;
    idle(6);
    check("simul_press", a_press, 4'b1001);
    idle(1);
    check("simul_press_end", a_press, 4'b0000);
    btn_in = 4'b0001;
    idle(6);
    check("simul_release", a_release, 4'b1000);
    check("simul_level", a_level, 4'b0001);
    btn_in = 4'b0000;
    idle(10);

    // Asynchronous reset 15 cycles into a ch0 hold
    btn_in = 4'b0001;
    idle(6);
    check("rst_hold_press", a_press, 4'b0001);
    idle(15);
    check("rst_hold_level_before", a_level, 4'b0001);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");
    idle(2);
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("rst_exit_press", a_press, (n == 6) ? 4'b0001 : 4'b0000);
    end
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      check("rst_exit_rpt", a_rpt, (n == 20) ? 4'b0001 : 4'b0000);
    end
    btn_in = 4'b0000;
    idle(10);

    // Randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 29) == 0) btn_in[i] = ~btn_in[i];
      end
      if (c == 1500) begin
        #2 rst = 1'b1;
        #1 check_all_zero("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn_in = 4'b0000;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel push-button front end: synchronizes, debounces and edge-detects N_CH raw button inputs.
- Generates one-cycle press and release pulses, plus an optional long-press auto-repeat pulse train.
- Sits between board buttons and game/control logic such as the FSM, dino and score blocks.
- Replaces per-button debounce/one-pulse pairs; all channels run in the same clock domain.

Parameters:
- N_CH, 4: number of independent button channels.
- STABLE_CNT, 16: consecutive cycles a synchronized input must differ from the debounced level before the level flips; must be >= 1.
- HOLD_CNT, 50000000: cycles of continuous debounced-high before the first repeat pulse; must be >= 1.
- REPEAT_CNT, 12500000: cycles between subsequent repeat pulses; must be >= 1.
- REPEAT_EN, 1: 1 enables repeat pulses on all channels; 0 forces rpt to 0.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- btn_in, input, N_CH: raw asynchronous button levels, active-high.
- btn_level, output, N_CH: debounced level per channel.
- btn_press, output, N_CH: one-cycle pulse on a debounced 0->1 transition.
- btn_release, output, N_CH: one-cycle pulse on a debounced 1->0 transition.
- btn_rpt, output, N_CH: one-cycle auto-repeat pulse while a button is held.

Behaviour:
- Reset (asynchronous, rst=1) clears the following immediately and holds them at 0 while rst is high:
  - synchronizer flops, stability counters, hold/repeat counters;
  - btn_level, btn_press, btn_release, btn_rpt.
- Synchronizer:
  - Two flops per channel; sync[i] equals btn_in[i] as sampled 2 edges earlier.
  - Nothing downstream sees btn_in directly.
- Debounce, per channel, each edge:
  - If sync != btn_level: the stability counter increments.
  - If sync == btn_level: the counter clears to 0.
  - When the counter equals STABLE_CNT-1 and sync != btn_level: btn_level <= sync and the counter clears.
  - Any glitch that returns to the current level before the count completes restarts counting from 0.
  - Counter width is $clog2(STABLE_CNT+1); it never wraps.
- Latency: a clean input edge sampled at edge k makes btn_level change at edge k+1+STABLE_CNT. With STABLE_CNT=1 this is edge k+2.
- Press/release:
  - Registered, asserted for exactly the first cycle in which the new btn_level is visible.
  - btn_press and btn_release on the same channel are never high together.
  - Channels are fully independent; simultaneous events on several channels each produce their own pulses.
- Repeat: hold counter per channel, two states IDLE / HOLD.
  - IDLE -> HOLD on a press; the counter loads 1.
  - In HOLD the counter increments each cycle.
  - First btn_rpt fires in the cycle the counter reaches HOLD_CNT, i.e. HOLD_CNT cycles after btn_press.
  - The counter then reloads to 1, and subsequent btn_rpt pulses fire every REPEAT_CNT cycles.
  - A release returns the channel to IDLE and clears the counter in the same edge. btn_rpt is never asserted in the release cycle or afterwards.
  - Counter width is $clog2(max(HOLD_CNT,REPEAT_CNT)+1).
  - With REPEAT_EN=0, btn_rpt is constant 0 and the hold logic may be optimized away.
- btn_in high at reset release: treated as a normal press. btn_press fires STABLE_CNT+2 edges after the first post-reset edge (2-cycle sync fill, then the STABLE_CNT count).
- Reset mid-count or mid-hold: all progress is lost, outputs drop to 0 asynchronously, and no pulse is emitted during or on exit from reset.

Test Plan (N_CH=4, STABLE_CNT=4, HOLD_CNT=20, REPEAT_CNT=8):
1. Clean press on ch0: btn_in[0] 0->1 sampled at edge k.
   - btn_level[0]=1 and btn_press[0]=1 for one cycle at edge k+5.
   - Other channels stay 0.
2. Bounce on ch1: pattern 1,0,1,1,0,1,1,1,1,1 sampled on consecutive edges.
   - btn_level[1] rises only after the final four-run of sync=1.
   - Exactly one btn_press[1]; no btn_release[1].
3. Hold ch2 for 60 cycles after its press.
   - btn_rpt[2] pulses at press+20, +28, +36, +44, +52, +60 (while still held).
   - Release: btn_release[2] one cycle, no further btn_rpt.
4. Simultaneous: ch0 and ch3 pressed on the same edge.
   - btn_press=4'b1001 for one cycle.
   - Releasing only ch3 later gives btn_release=4'b1000 and leaves btn_level[0]=1.
5. Reset mid-hold: assert rst asynchronously (between edges) 15 cycles into a ch0 hold.
   - All outputs go 0 at once, before the next edge.
   - After release with btn_in[0] still 1: btn_press[0] again at 6 edges, first btn_rpt[0] 20 cycles after that.
6. REPEAT_EN=0 build, repeat scenario 3: btn_rpt stays 4'b0000 throughout; press/release unchanged.
